bmu_modport: RTL and testbench



---
 rtl/bmu_modport_pkg.sv | 89 ++++++++
 rtl/bmu_modport_bitcount.sv | 25 ++
 rtl/bmu_modport.sv | 111 +++++++++++
 tb/tb_bmu_modport.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bmu_modport_pkg.sv
// Shared definitions for the bit-manipulation unit: request packet, widths, helpers.
package BmuDef;

  localparam int unsigned XLen    = 32;
  localparam int unsigned ShW     = 5;
  localparam int unsigned CntW    = 6;
  localparam int unsigned AluPktW = 44;

  // Two top bits are reserved padding; the named fields follow MSB to LSB.
  typedef struct packed {
    logic [1:0] rsvd;
    logic clz;
    logic ctz;
    logic cpop;
    logic siext_b;
    logic siext_h;
    logic min;
    logic max;
    logic pack;
    logic packu;
    logic packh;
    logic rol;
    logic ror;
    logic grev;
    logic gorc;
    logic zbb;
    logic bset;
    logic bclr;
    logic binv;
    logic bext;
    logic sh1add;
    logic sh2add;
    logic sh3add;
    logic zba;
    logic land;
    logic lor;
    logic lxor;
    logic sll;
    logic srl;
    logic sra;
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic add;
    logic sub;
    logic slt;
    logic unsign;
    logic jal;
    logic predict_t;
    logic predict_nt;
    logic csr_write;
    logic csr_imm;
  } rtl_alu_pkt_t;

  // Kinds of bench stimulus items.
  typedef enum logic [1:0] {KindReq, KindIdle, KindRst} itemKind;

  // Generalized reverse (orc=0) or OR-combine (orc=1) over stages 1,2,4,8,16.
  function automatic logic [XLen-1:0] gen_rev(input logic [XLen-1:0] a,
                                               input logic [ShW-1:0] sh,
                                               input logic orc);
    logic [XLen-1:0] x;
    logic [XLen-1:0] sw;
    x = a;
    if (sh[0]) begin
      sw = ((x & 32'h5555_5555) << 1) | ((x >> 1) & 32'h5555_5555);
      x  = orc ? (x | sw) : sw;
    end
    if (sh[1]) begin
      sw = ((x & 32'h3333_3333) << 2) | ((x >> 2) & 32'h3333_3333);
      x  = orc ? (x | sw) : sw;
    end
    if (sh[2]) begin
      sw = ((x & 32'h0F0F_0F0F) << 4) | ((x >> 4) & 32'h0F0F_0F0F);
      x  = orc ? (x | sw) : sw;
    end
    if (sh[3]) begin
      sw = ((x & 32'h00FF_00FF) << 8) | ((x >> 8) & 32'h00FF_00FF);
      x  = orc ? (x | sw) : sw;
    end
    if (sh[4]) begin
      sw = ((x & 32'h0000_FFFF) << 16) | ((x >> 16) & 32'h0000_FFFF);
      x  = orc ? (x | sw) : sw;
    end
    return x;
  endfunction

endpackage

// File: rtl/bmu_modport_bitcount.sv
// Combinational leading-zero, trailing-zero and population counts of one operand.
module bmu_bitcount
  import BmuDef::*;
(
  input  logic [XLen-1:0] a_i,
  output logic [CntW-1:0] clz_o,
  output logic [CntW-1:0] ctz_o,
  output logic [CntW-1:0] cpop_o
);

  // Highest set bit wins for clz, lowest for ctz; a zero operand gives 32 for both.
  always_comb begin
    clz_o  = CntW'(XLen);
    ctz_o  = CntW'(XLen);
    cpop_o = '0;
    for (int i = 0; i < XLen; i++) begin
      if (a_i[i]) clz_o = CntW'(XLen - 1 - i);
      cpop_o = cpop_o + CntW'(a_i[i]);
    end
    for (int i = XLen - 1; i >= 0; i--) begin
      if (a_i[i]) ctz_o = CntW'(i);
    end
  end

endmodule

// File: rtl/bmu_modport.sv
// Single-cycle RV32 bit-manipulation unit with registered result and illegal-request flag.
module bmu_modport
  import BmuDef::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            scanMode,
  input  logic            validIn,
  input  rtl_alu_pkt_t    ap,
  input  logic            csrRenIn,
  input  logic [XLen-1:0] csrRdataIn,
  input  logic [XLen-1:0] aIn,
  input  logic [XLen-1:0] bIn,
  output logic [XLen-1:0] resultFf,
  output logic            error
);

  logic [XLen-1:0] result_d, result_q;
  logic            error_d, error_q;
  logic [CntW-1:0] clz_cnt, ctz_cnt, cpop_cnt;
  logic [ShW-1:0]  sh;
  logic            lt;
  logic            legal;
  logic            unsupported;
  logic [37:0]     prim;
  logic [XLen-1:0] b_log;
  logic [XLen-1:0] one_hot_sh;
  logic            unused_in;

  // Scan enable and reserved packet bits carry no function.
  assign unused_in = ^{scanMode, ap.rsvd};

  assign sh         = bIn[ShW-1:0];
  assign lt         = ap.unsign ? (aIn < bIn) : ($signed(aIn) < $signed(bIn));
  assign b_log      = ap.zbb ? ~bIn : bIn;
  assign one_hot_sh = XLen'(1) << sh;

  // Every non-modifier bit is a primary op.
  assign prim = {ap.clz, ap.ctz, ap.cpop, ap.siext_b, ap.siext_h, ap.min, ap.max, ap.pack,
                 ap.packu, ap.packh, ap.rol, ap.ror, ap.grev, ap.gorc, ap.bset, ap.bclr,
                 ap.binv, ap.bext, ap.sh1add, ap.sh2add, ap.sh3add, ap.land, ap.lor, ap.lxor,
                 ap.sll, ap.srl, ap.sra, ap.beq, ap.bne, ap.blt, ap.bge, ap.add, ap.sub,
                 ap.slt, ap.jal, ap.predict_t, ap.predict_nt, ap.csr_write};

  assign unsupported = ap.beq | ap.bne | ap.blt | ap.bge | ap.jal | ap.predict_t |
                       ap.predict_nt | ((ap.sh1add | ap.sh2add | ap.sh3add) & ~ap.zba);

  assign legal = (csrRenIn ? (prim == '0) : $onehot(prim)) & ~unsupported;

  bmu_bitcount u_bitcount (
    .a_i    (aIn),
    .clz_o  (clz_cnt),
    .ctz_o  (ctz_cnt),
    .cpop_o (cpop_cnt)
  );

  // Result select; legality guarantees at most one op bit is live.
  always_comb begin
    result_d = '0;
    if (csrRenIn)          result_d = csrRdataIn;
    else if (ap.add)       result_d = aIn + bIn;
    else if (ap.sub)       result_d = aIn - bIn;
    else if (ap.slt)       result_d = {31'b0, lt};
    else if (ap.land)      result_d = aIn & b_log;
    else if (ap.lor)       result_d = aIn | b_log;
    else if (ap.lxor)      result_d = aIn ^ b_log;
    else if (ap.sll)       result_d = aIn << sh;
    else if (ap.srl)       result_d = aIn >> sh;
    else if (ap.sra)       result_d = XLen'($signed(aIn) >>> sh);
    else if (ap.rol)       result_d = (aIn << sh) | (aIn >> (6'd32 - {1'b0, sh}));
    else if (ap.ror)       result_d = (aIn >> sh) | (aIn << (6'd32 - {1'b0, sh}));
    else if (ap.sh1add)    result_d = (aIn << 1) + bIn;
    else if (ap.sh2add)    result_d = (aIn << 2) + bIn;
    else if (ap.sh3add)    result_d = (aIn << 3) + bIn;
    else if (ap.clz)       result_d = XLen'(clz_cnt);
    else if (ap.ctz)       result_d = XLen'(ctz_cnt);
    else if (ap.cpop)      result_d = XLen'(cpop_cnt);
    else if (ap.siext_b)   result_d = {{24{aIn[7]}}, aIn[7:0]};
    else if (ap.siext_h)   result_d = {{16{aIn[15]}}, aIn[15:0]};
    else if (ap.min)       result_d = lt ? aIn : bIn;
    else if (ap.max)       result_d = lt ? bIn : aIn;
    else if (ap.pack)      result_d = {bIn[15:0], aIn[15:0]};
    else if (ap.packu)     result_d = {bIn[31:16], aIn[31:16]};
    else if (ap.packh)     result_d = {16'b0, bIn[7:0], aIn[7:0]};
    else if (ap.grev)      result_d = gen_rev(aIn, sh, 1'b0);
    else if (ap.gorc)      result_d = gen_rev(aIn, sh, 1'b1);
    else if (ap.bset)      result_d = aIn | one_hot_sh;
    else if (ap.bclr)      result_d = aIn & ~one_hot_sh;
    else if (ap.binv)      result_d = aIn ^ one_hot_sh;
    else if (ap.bext)      result_d = {31'b0, aIn[sh]};
    else if (ap.csr_write) result_d = ap.csr_imm ? bIn : aIn;
  end

  // Output registers: illegal request zeroes the result, idle cycles hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      error_q  <= 1'b0;
    end else if (validIn) begin
      result_q <= legal ? result_d : '0;
      error_q  <= ~legal;
    end else begin
      error_q  <= 1'b0;
    end
  end

  assign error_d  = error_q;
  assign resultFf = result_q;
  assign error    = error_d;

endmodule

// File: tb/tb_bmu_modport.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares.
module tb_bmu_modport;
  import BmuDef::*;

  logic         clk = 1'b0;
  logic         rst, scan_mode, valid_in, csr_ren;
  rtl_alu_pkt_t ap_s;
  logic [31:0]  csr_rdata, a_in, b_in, result_ff;
  logic         err_out;

  typedef struct {
    logic [31:0] res;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] prev_res = '0;

  // Field positions in the 44-bit packet (LSB = 0).
  localparam int CSR_IMM = 0, CSR_WRITE = 1, PRED_NT = 2, PRED_T = 3, JAL = 4, UNSIGN = 5;
  localparam int SLT = 6, SUB = 7, ADD = 8, BGE = 9, BLT = 10, BNE = 11, BEQ = 12;
  localparam int SRA = 13, SRL = 14, SLL = 15, LXOR = 16, LOR = 17, LAND = 18, ZBA = 19;
  localparam int SH3ADD = 20, SH2ADD = 21, SH1ADD = 22, BEXT = 23, BINV = 24, BCLR = 25;
  localparam int BSET = 26, ZBB = 27, GORC = 28, GREV = 29, ROR = 30, ROL = 31;
  localparam int PACKH = 32, PACKU = 33, PACK = 34, MAX = 35, MIN = 36, SIEXT_H = 37;
  localparam int SIEXT_B = 38, CPOP = 39, CTZ = 40, CLZ = 41;

  int prim_pos[$];

  bmu_modport dut (
    .clk        (clk),
    .rst        (rst),
    .scanMode   (scan_mode),
    .validIn    (valid_in),
    .ap         (ap_s),
    .csrRenIn   (csr_ren),
    .csrRdataIn (csr_rdata),
    .aIn        (a_in),
    .bIn        (b_in),
    .resultFf   (result_ff),
    .error      (err_out)
  );

  always #5 clk = ~clk;

  function automatic rtl_alu_pkt_t pk(input int b0, input int b1 = -1, input int b2 = -1);
    logic [43:0] v;
    v = '0;
    if (b0 >= 0) v[b0] = 1'b1;
    if (b1 >= 0) v[b1] = 1'b1;
    if (b2 >= 0) v[b2] = 1'b1;
    return rtl_alu_pkt_t'(v);
  endfunction

  // Reference model of one valid request: returns {error, result}.
  function automatic logic [32:0] model(input rtl_alu_pkt_t p, input logic [31:0] a,
                                        input logic [31:0] b, input logic ren,
                                        input logic [31:0] rd);
    logic [43:0] v;
    logic [63:0] w;
    logic [31:0] r, bl;
    int          n, sh, cnt;
    bit          bad, lt;
    v   = p;
    n   = 0;
    foreach (prim_pos[i]) n += int'(v[prim_pos[i]]);
    bad = p.beq || p.bne || p.blt || p.bge || p.jal || p.predict_t || p.predict_nt ||
          ((p.sh1add || p.sh2add || p.sh3add) && !p.zba);
    if (bad || (ren ? (n != 0) : (n != 1))) return {1'b1, 32'h0};
    sh  = int'(b[4:0]);
    lt  = p.unsign ? (a < b) : ($signed(a) < $signed(b));
    bl  = p.zbb ? ~b : b;
    r   = '0;
    if (ren) r = rd;
    else if (p.add) r = a + b;
    else if (p.sub) r = a - b;
    else if (p.slt) r = lt ? 32'd1 : 32'd0;
    else if (p.land) r = a & bl;
    else if (p.lor) r = a | bl;
    else if (p.lxor) r = a ^ bl;
    else if (p.sll) r = a << sh;
    else if (p.srl) r = a >> sh;
    else if (p.sra) r = $signed(a) >>> sh;
    else if (p.rol) begin w = {a, a} << sh; r = w[63:32]; end
    else if (p.ror) begin w = {a, a} >> sh; r = w[31:0]; end
    else if (p.sh1add) r = a * 2 + b;
    else if (p.sh2add) r = a * 4 + b;
    else if (p.sh3add) r = a * 8 + b;
    else if (p.clz) begin cnt = 0; for (int i = 31; i >= 0 && !a[i]; i--) cnt++; r = cnt; end
    else if (p.ctz) begin cnt = 0; for (int i = 0; i < 32 && !a[i]; i++) cnt++; r = cnt; end
    else if (p.cpop) r = $countones(a);
    else if (p.siext_b) r = $signed(a[7:0]);
    else if (p.siext_h) r = $signed(a[15:0]);
    else if (p.min) r = lt ? a : b;
    else if (p.max) r = lt ? b : a;
    else if (p.pack) r = {b[15:0], a[15:0]};
    else if (p.packu) r = {b[31:16], a[31:16]};
    else if (p.packh) r = {16'h0, b[7:0], a[7:0]};
    else if (p.grev) for (int i = 0; i < 32; i++) r[i] = a[i ^ sh];
    else if (p.gorc) begin
      for (int i = 0; i < 32; i++)
        for (int k = 0; k < 32; k++)
          if ((k & ~sh) == 0) r[i] = r[i] | a[i ^ k];
    end
    else if (p.bset) r = a | (32'd1 << sh);
    else if (p.bclr) r = a & ~(32'd1 << sh);
    else if (p.binv) r = a ^ (32'd1 << sh);
    else if (p.bext) r = {31'b0, a[sh]};
    else if (p.csr_write) r = p.csr_imm ? b : a;
    return {1'b0, r};
  endfunction

  // Drive one cycle of stimulus on the negedge and push its expected outcome.
  task automatic drive(input itemKind kind, input rtl_alu_pkt_t p, input logic [31:0] a,
                       input logic [31:0] b, input logic ren, input logic [31:0] rd,
                       input logic [31:0] exp_res, input logic exp_err, input string name);
    exp_t e;
    @(negedge clk);
    rst       = (kind == KindRst);
    valid_in  = (kind != KindIdle);
    ap_s      = p;
    a_in      = a;
    b_in      = b;
    csr_ren   = ren;
    csr_rdata = rd;
    scan_mode = 1'($urandom);
    e.name    = name;
    if (kind == KindRst) begin
      e.res = '0; e.err = 1'b0;
    end else if (kind == KindIdle) begin
      e.res = prev_res; e.err = 1'b0;
    end else begin
      e.res = exp_res; e.err = exp_err;
    end
    prev_res = e.res;
    sb_q.push_back(e);
  endtask

  task automatic req(input rtl_alu_pkt_t p, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_err, input string name);
    drive(KindReq, p, a, b, 1'b0, 32'h0, exp_res, exp_err, name);
  endtask

  task automatic rand_item(input int idx);
    logic [32:0]  m;
    logic [43:0]  v;
    rtl_alu_pkt_t p;
    logic [31:0]  a, b, rd;
    logic         ren;
    int           sel;
    a   = $urandom;
    b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
    rd  = $urandom;
    ren = 1'b0;
    v   = '0;
    sel = $urandom_range(0, 99);
    if (sel < 5) begin
      drive(KindRst, pk(ADD), a, b, 1'b0, rd, 32'h0, 1'b0, $sformatf("rnd%0d_rst", idx));
      return;
    end
    if (sel < 12) begin
      drive(KindIdle, pk(ADD), a, b, 1'b0, rd, 32'h0, 1'b0, $sformatf("rnd%0d_idle", idx));
      return;
    end
    if (sel < 18) begin
      ren = 1'b1;
      if (sel < 16) v[prim_pos[$urandom_range(0, prim_pos.size() - 1)]] = 1'b1;
      v = ($urandom_range(0, 1) == 0) ? v : '0;
    end else begin
      v[prim_pos[$urandom_range(0, prim_pos.size() - 1)]] = 1'b1;
      if (sel > 93) v[prim_pos[$urandom_range(0, prim_pos.size() - 1)]] = 1'b1;
    end
    v[ZBA]     = ($urandom_range(0, 3) != 0);
    v[ZBB]     = 1'($urandom);
    v[UNSIGN]  = 1'($urandom);
    v[CSR_IMM] = 1'($urandom);
    p = rtl_alu_pkt_t'(v);
    m = model(p, a, b, ren, rd);
    drive(KindReq, p, a, b, ren, rd, m[31:0], m[32], $sformatf("rnd%0d", idx));
  endtask

  // Monitor: after every posedge, pop one expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (result_ff !== e.res || err_out !== e.err) begin
          n_fail++;
          $display("FAIL %s: got res=%h err=%b, want res=%h err=%b",
                   e.name, result_ff, err_out, e.res, e.err);
        end
      end
    end
  end

  initial begin
    int budget;
    for (int i = 0; i <= CLZ; i++)
      if (i != CSR_IMM && i != UNSIGN && i != ZBA && i != ZBB) prim_pos.push_back(i);
    rst = 1'b0; valid_in = 1'b0; ap_s = '0; a_in = '0; b_in = '0;
    csr_ren = 1'b0; csr_rdata = '0; scan_mode = 1'b0;

    drive(KindRst, pk(ADD), 32'd1, 32'd2, 1'b0, 32'h0, 32'h0, 1'b0, "reset_with_add");
    req(pk(ADD), 32'd5, 32'd7, 32'd12, 1'b0, "add_5_7");
    req(pk(SUB), 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, "sub_0_1");
    req(pk(SLT), 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt_signed");
    req(pk(SLT, UNSIGN), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "slt_unsigned");
    req(pk(MIN), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, "min_signed");
    req(pk(MAX), 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "max_signed");
    req(pk(MIN, UNSIGN), 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "min_unsigned");
    req(pk(MAX, UNSIGN), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, "max_unsigned");
    req(pk(CLZ), 32'h0001_0000, 32'd0, 32'd15, 1'b0, "clz");
    req(pk(CTZ), 32'h0, 32'd0, 32'd32, 1'b0, "ctz_zero");
    req(pk(CPOP), 32'hF0F0_F0F0, 32'd0, 32'd16, 1'b0, "cpop");
    req(pk(ROL), 32'h8000_0001, 32'd1, 32'h0000_0003, 1'b0, "rol");
    req(pk(GORC), 32'h0001_0200, 32'd7, 32'h00FF_FF00, 1'b0, "gorc");
    req(pk(GREV), 32'h1122_3344, 32'd24, 32'h4433_2211, 1'b0, "grev");
    req(pk(SH2ADD, ZBA), 32'd3, 32'd10, 32'd22, 1'b0, "sh2add");
    req(pk(SH2ADD), 32'd3, 32'd10, 32'd0, 1'b1, "sh2add_no_zba");
    req(pk(BEXT), 32'h8, 32'd3, 32'd1, 1'b0, "bext");
    req(pk(PACKH), 32'h12, 32'h34, 32'h3412, 1'b0, "packh");
    req(pk(ADD, SUB), 32'd1, 32'd1, 32'd0, 1'b1, "add_plus_sub");
    req(pk(-1), 32'd1, 32'd1, 32'd0, 1'b1, "no_op_bits");
    req(pk(BEQ), 32'd1, 32'd1, 32'd0, 1'b1, "beq");
    req(pk(ADD), 32'd2, 32'd3, 32'd5, 1'b0, "legal_after_err");
    drive(KindReq, pk(-1), 32'd1, 32'd2, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "csr_read");
    req(pk(CSR_WRITE, CSR_IMM), 32'hAAAA_5555, 32'h1F, 32'h1F, 1'b0, "csr_write_imm");
    drive(KindIdle, pk(ADD), 32'd9, 32'd9, 1'b0, 32'h0, 32'h0, 1'b0, "idle_hold");
    drive(KindIdle, pk(SUB), 32'd9, 32'd1, 1'b0, 32'h0, 32'h0, 1'b0, "idle_hold2");

    for (int i = 0; i < 400; i++) rand_item(i);

    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
